// File: rtl/i2c_line_monitor.sv
// ---------------------------------------------------------------------------
// i2c_line_monitor
// Conditions the raw open-drain SCL/SDA readbacks coming from the pad wrapper
// (synchroniser followed by a glitch filter) and derives the bus events used by
// the I2C byte/bit controller: SCL edges, START/STOP, bus-busy, arbitration
// loss and clock stretching.
//
// Optional feature: define I2C_MON_TIMEOUT_EN to enable the SCL-low bus
// timeout. Without it bus_timeout is tied low and the timeout counter is
// absent.
//
// Parameters
//   SYNC_STAGES  flops per input synchroniser (>= 2)
//   FILT_LEN     consecutive differing samples before a filtered line moves (>= 1)
//   TIMEOUT_CYC  SCL-low cycles while busy before a timeout (2..65536)
//
// Ports
//   clk          system clock
//   reset        synchronous reset, active low
//   scl_i/sda_i  raw pad readbacks (asynchronous)
//   scl_o/sda_o  local drive values (1 = released, 0 = pulled low)
//   scl_f/sda_f  filtered lines
//   scl_rise     1-cycle pulse on a filtered SCL rising edge
//   scl_fall     1-cycle pulse on a filtered SCL falling edge
//   start_det    1-cycle pulse on START / repeated START
//   stop_det     1-cycle pulse on STOP
//   bus_busy     level, START until STOP (or timeout)
//   arb_lost     1-cycle pulse: SDA released locally but read low at SCL rise
//   clk_stretch  level, SCL released locally but filtered SCL low
//   bus_timeout  1-cycle pulse on an SCL-low timeout
// ---------------------------------------------------------------------------
module i2c_line_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  input  logic scl_o,
  input  logic sda_o,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic arb_lost,
  output logic clk_stretch,
  output logic bus_timeout
);

  localparam int unsigned LINES = 2;
  localparam int unsigned L_SCL = 0;
  localparam int unsigned L_SDA = 1;
  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  // Elaboration-time parameter legality checks
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 1) begin : g_chk_filt
    $error("FILT_LEN must be at least 1");
  end
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65536)) begin : g_chk_tout
    $error("TIMEOUT_CYC must be within 2..65536");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_e;

  // Line index 0 = SCL, 1 = SDA throughout
  logic [LINES-1:0]                  raw_c;
  logic [LINES-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [LINES-1:0]                  sync_s_c;
  logic [LINES-1:0]                  filt_q, filt_d;
  logic [LINES-1:0][CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [LINES-1:0]                  prev_q;

  bus_state_e state_q, state_d;

  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic arb_q, arb_d;
  logic stretch_q, stretch_d;

  logic p_scl_c, f_scl_c, p_sda_c, f_sda_c;
  logic start_c, stop_c;
  logic to_hit_c;

  assign raw_c = {sda_i, scl_i};

  // Synchroniser shift and tap
  always_comb begin
    sync_d   = '0;
    sync_s_c = '0;
    for (int i = 0; i < int'(LINES); i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], raw_c[i]};
      sync_s_c[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Glitch filter: the line only moves after FILT_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < int'(LINES); i++) begin
      if (sync_s_c[i] != filt_q[i]) begin
        if (fcnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_s_c[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign p_scl_c = prev_q[L_SCL];
  assign f_scl_c = filt_q[L_SCL];
  assign p_sda_c = prev_q[L_SDA];
  assign f_sda_c = filt_q[L_SDA];

  // START/STOP need SCL high in both samples, so a simultaneous SCL+SDA change never qualifies
  assign start_c = p_scl_c & f_scl_c & p_sda_c & ~f_sda_c;
  assign stop_c  = p_scl_c & f_scl_c & ~p_sda_c & f_sda_c;

`ifdef I2C_MON_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] tcnt_q, tcnt_d;
  logic        timeout_q;

  // SCL-low timeout counter, only runs while the bus is busy
  always_comb begin
    tcnt_d   = tcnt_q;
    to_hit_c = 1'b0;
    if ((state_q != ST_BUSY) || f_scl_c) begin
      tcnt_d = '0;
    end else if (tcnt_q == TO_LAST) begin
      to_hit_c = 1'b1;
      tcnt_d   = '0;
    end else if (tcnt_q != 16'hFFFF) begin
      tcnt_d = tcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= to_hit_c;
    end
  end

  assign bus_timeout = timeout_q;
`else
  assign to_hit_c    = 1'b0;
  assign bus_timeout = 1'b0;
`endif

  // Bus state and registered event outputs
  always_comb begin
    state_d   = state_q;
    rise_d    = ~p_scl_c & f_scl_c;
    fall_d    = p_scl_c & ~f_scl_c;
    start_d   = start_c;
    stop_d    = stop_c;
    arb_d     = 1'b0;
    stretch_d = scl_o & ~f_scl_c;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Repeated START keeps the bus busy
        if (stop_c || to_hit_c) begin
          state_d = ST_IDLE;
        end
        arb_d = rise_d & sda_o & ~f_sda_c;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '1;
      filt_q    <= '1;
      fcnt_q    <= '0;
      prev_q    <= '1;
      state_q   <= ST_IDLE;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      arb_q     <= 1'b0;
      stretch_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      prev_q    <= filt_q;
      state_q   <= state_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      arb_q     <= arb_d;
      stretch_q <= stretch_d;
    end
  end

  assign scl_f       = filt_q[L_SCL];
  assign sda_f       = filt_q[L_SDA];
  assign scl_rise    = rise_q;
  assign scl_fall    = fall_q;
  assign start_det   = start_q;
  assign stop_det    = stop_q;
  assign bus_busy    = (state_q == ST_BUSY);
  assign arb_lost    = arb_q;
  assign clk_stretch = stretch_q;

endmodule

// File: tb/tb_i2c_line_monitor.sv
// ---------------------------------------------------------------------------
// Self-checking bench for i2c_line_monitor. Directed scenarios check pulse
// counts and latencies; a randomized run compares every output each cycle
// against a behavioural model built from sample histories.
// ---------------------------------------------------------------------------
module tb_i2c_line_monitor;

  localparam int unsigned SYNC = 2;
  localparam int unsigned FLEN = 4;
  localparam int unsigned TOUT = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic scl_i = 1'b1;
  logic sda_i = 1'b1;
  logic scl_o = 1'b1;
  logic sda_o = 1'b1;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic bus_busy, arb_lost, clk_stretch, bus_timeout;

  always #5 clk = ~clk;

  i2c_line_monitor #(
    .SYNC_STAGES(SYNC),
    .FILT_LEN   (FLEN),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_f      (scl_f),
    .sda_f      (sda_f),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .arb_lost   (arb_lost),
    .clk_stretch(clk_stretch),
    .bus_timeout(bus_timeout)
  );

  logic [9:0] obs;
  assign obs = {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det,
                bus_busy, arb_lost, clk_stretch, bus_timeout};

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit   m_scl_pipe[$], m_sda_pipe[$];
  bit   m_scl_win[$], m_sda_win[$];
  bit   m_fscl, m_fsda, m_pscl, m_psda, m_busy;
  int   m_low_run;
  logic [9:0] exp_v = '0;

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit s_scl, s_sda, n_scl, n_sda, rise, fall, st, sp, arb, stretch, to;
    int agree_scl, agree_sda;
    if (!reset) begin
      m_scl_pipe = {}; m_sda_pipe = {};
      for (int k = 0; k < int'(SYNC); k++) begin
        m_scl_pipe.push_back(1'b1);
        m_sda_pipe.push_back(1'b1);
      end
      m_scl_win = {}; m_sda_win = {};
      m_fscl = 1; m_fsda = 1; m_pscl = 1; m_psda = 1; m_busy = 0; m_low_run = 0;
      exp_v = 10'b11_0000_0000;
      return;
    end
    // line value seen after SYNC flops = raw value from SYNC edges ago
    s_scl = m_scl_pipe.pop_front(); m_scl_pipe.push_back(scl_i);
    s_sda = m_sda_pipe.pop_front(); m_sda_pipe.push_back(sda_i);
    m_scl_win.push_back(s_scl); if (m_scl_win.size() > FLEN) void'(m_scl_win.pop_front());
    m_sda_win.push_back(s_sda); if (m_sda_win.size() > FLEN) void'(m_sda_win.pop_front());
    // a filtered line moves once the last FLEN samples all disagree with it
    agree_scl = 0; agree_sda = 0;
    foreach (m_scl_win[k]) if (m_scl_win[k] != m_fscl) agree_scl++;
    foreach (m_sda_win[k]) if (m_sda_win[k] != m_fsda) agree_sda++;
    n_scl = (agree_scl == int'(FLEN)) ? !m_fscl : m_fscl;
    n_sda = (agree_sda == int'(FLEN)) ? !m_fsda : m_fsda;
    // events from the last two filtered values
    rise    = !m_pscl && m_fscl;
    fall    = m_pscl && !m_fscl;
    st      = m_pscl && m_fscl && m_psda && !m_fsda;
    sp      = m_pscl && m_fscl && !m_psda && m_fsda;
    arb     = rise && m_busy && sda_o && !m_fsda;
    stretch = scl_o && !m_fscl;
    to      = 0;
`ifdef I2C_MON_TIMEOUT_EN
    if (m_busy && !m_fscl) begin
      m_low_run++;
      if (m_low_run == int'(TOUT)) begin
        to = 1;
        m_low_run = 0;
      end
    end else begin
      m_low_run = 0;
    end
`endif
    if (st) m_busy = 1;
    if (sp || to) m_busy = 0;
    m_pscl = m_fscl; m_psda = m_fsda;
    m_fscl = n_scl;  m_fsda = n_sda;
    exp_v = {m_fscl, m_fsda, rise, fall, st, sp, m_busy, arb, stretch, to};
  endtask

  // One clock: edge, model update, then settle to the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- stimulus pacing with pulse counters ----------------
  int c_rise, c_fall, c_start, c_stop, c_arb, c_to, c_sdalow, c_idle;

  task automatic clr();
    c_rise = 0; c_fall = 0; c_start = 0; c_stop = 0;
    c_arb = 0; c_to = 0; c_sdalow = 0; c_idle = 0;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      c_rise   += int'(scl_rise);
      c_fall   += int'(scl_fall);
      c_start  += int'(start_det);
      c_stop   += int'(stop_det);
      c_arb    += int'(arb_lost);
      c_to     += int'(bus_timeout);
      c_sdalow += int'(!sda_f);
      c_idle   += int'(!bus_busy);
    end
  endtask

  task automatic go_idle();
    scl_i = 1; sda_i = 1; hold(12);
  endtask

  task automatic do_start();
    scl_i = 1; sda_i = 0; hold(12);
  endtask

  task automatic do_stop();
    scl_i = 0; hold(10);
    sda_i = 0; hold(10);
    scl_i = 1; hold(10);
    sda_i = 1; hold(12);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 0; scl_i = 1; sda_i = 1; scl_o = 1; sda_o = 1;
    step(); step();
    n_cmp++;
    if (obs !== 10'b11_0000_0000) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", obs, 10'b11_0000_0000);
    end
    reset = 1;
    hold(3);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_release: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_glitch();
    go_idle(); clr();
    sda_i = 0; hold(3);
    sda_i = 1; hold(12);
    n_cmp++;
    if (c_sdalow !== 0) begin
      n_err++;
      $display("FAIL glitch_sda_f: got %0d low cycles want 0", c_sdalow);
    end
    n_cmp++;
    if (c_start !== 0) begin
      n_err++;
      $display("FAIL glitch_start: got %0d pulses want 0", c_start);
    end
  endtask

  task automatic test_start_stop();
    int lat;
    go_idle();
    sda_i = 0; lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (start_det === 1'b1) lat = c;
    end
    n_cmp++;
    if (lat !== 7) begin
      n_err++;
      $display("FAIL start_latency: got %0d want 7 (0 = not seen)", lat);
    end
    step();
    n_cmp++;
    if (bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_busy: got %b want 1", bus_busy);
    end
    hold(4);
    sda_i = 1; lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (stop_det === 1'b1) lat = c;
    end
    n_cmp++;
    if (lat !== 7) begin
      n_err++;
      $display("FAIL stop_latency: got %0d want 7 (0 = not seen)", lat);
    end
    n_cmp++;
    if (bus_busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_busy: got %b want 0", bus_busy);
    end
  endtask

  task automatic test_byte();
    go_idle(); do_start(); clr();
    for (int b = 0; b < 9; b++) begin
      scl_i = 0; hold(10);
      sda_i = 1'($urandom_range(0, 1)); hold(10);
      scl_i = 1; hold(20);
    end
    n_cmp++;
    if (c_rise !== 9 || c_fall !== 9) begin
      n_err++;
      $display("FAIL byte_edges: got rise=%0d fall=%0d want 9/9", c_rise, c_fall);
    end
    n_cmp++;
    if (c_start !== 0 || c_stop !== 0 || bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL byte_no_cond: got start=%0d stop=%0d busy=%b want 0/0/1",
               c_start, c_stop, bus_busy);
    end
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL byte_model: got %b want %b", obs, exp_v);
    end
    do_stop();
  endtask

  task automatic test_arb();
    go_idle(); do_start();
    scl_i = 0; hold(12);
    sda_o = 1; sda_i = 0; clr();
    scl_i = 1; hold(12);
    n_cmp++;
    if (c_arb !== 1 || c_rise !== 1) begin
      n_err++;
      $display("FAIL arb_released: got arb=%0d rise=%0d want 1/1", c_arb, c_rise);
    end
    scl_i = 0; hold(12);
    sda_o = 0; clr();
    scl_i = 1; hold(12);
    n_cmp++;
    if (c_arb !== 0) begin
      n_err++;
      $display("FAIL arb_driven: got %0d pulses want 0", c_arb);
    end
    sda_o = 1;
    do_stop();
  endtask

  task automatic test_back_to_back();
    go_idle(); do_start();
    scl_i = 0; hold(10);
    sda_i = 1; hold(10);
    scl_i = 1; hold(10);
    clr();
    sda_i = 0; hold(12);
    n_cmp++;
    if (c_start !== 1 || c_idle !== 0 || bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL repeated_start: got start=%0d idle=%0d busy=%b want 1/0/1",
               c_start, c_idle, bus_busy);
    end
    do_stop();
  endtask

  task automatic test_stretch_reset();
    go_idle(); do_start();
    scl_o = 1; scl_i = 0; hold(12);
    n_cmp++;
    if (clk_stretch !== 1'b1 || bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL stretch_on: got stretch=%b busy=%b want 1/1", clk_stretch, bus_busy);
    end
    scl_o = 0; hold(2);
    n_cmp++;
    if (clk_stretch !== 1'b0) begin
      n_err++;
      $display("FAIL stretch_off: got %b want 0", clk_stretch);
    end
    scl_o = 1;
    reset = 0; step(); reset = 1;
    n_cmp++;
    if (bus_busy !== 1'b0 || scl_f !== 1'b1 || sda_f !== 1'b1 || stop_det !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reset: got busy=%b scl_f=%b sda_f=%b stop=%b want 0/1/1/0",
               bus_busy, scl_f, sda_f, stop_det);
    end
    clr(); hold(12);
    n_cmp++;
    if (c_stop !== 0 || obs !== exp_v) begin
      n_err++;
      $display("FAIL post_reset: got stop=%0d obs=%b want 0 obs=%b", c_stop, obs, exp_v);
    end
    scl_i = 1; sda_i = 1; hold(12);
  endtask

  task automatic test_timeout();
    go_idle(); do_start(); clr();
    scl_i = 0; hold(100);
`ifdef I2C_MON_TIMEOUT_EN
    n_cmp++;
    if (c_to !== 1 || bus_busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_on: got pulses=%0d busy=%b want 1/0", c_to, bus_busy);
    end
`else
    n_cmp++;
    if (c_to !== 0 || bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_off: got pulses=%0d busy=%b want 0/1", c_to, bus_busy);
    end
`endif
    scl_i = 1; hold(12);
    sda_i = 1; hold(12);
    n_cmp++;
    if (bus_busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_cleanup_busy: got %b want 0", bus_busy);
    end
  endtask

  task automatic test_random();
    int cyc;
    cyc = 0;
    while (cyc < 800) begin
      case ($urandom_range(0, 3))
        0: scl_i = !scl_i;
        1: sda_i = !sda_i;
        2: begin scl_i = !scl_i; sda_i = !sda_i; end
        default: ;
      endcase
      scl_o = ($urandom_range(0, 3) != 0);
      sda_o = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < int'($urandom_range(1, 9)); k++) begin
        step();
        reset = 1;
        cyc++;
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL random_cycle%0d: got %b want %b", cyc, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start_stop();
    test_byte();
    test_arb();
    test_back_to_back();
    test_stretch_reset();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
